// File: rtl/prbs5_checker_if.sv
// rtl/prbs5_checker_if.sv - serial stream and status bundle for the PRBS5 checker
interface prbs5_checker_if;
    logic        in_valid;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_count, state
    );

    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/prbs5_checker.sv
// rtl/prbs5_checker.sv - PRBS5 (x^5+x^3+1) stream checker with lock FSM and error counter
module prbs5_checker #(
    parameter int LOCK_THRESH   = 8,
    parameter int UNLOCK_THRESH = 4
) (
    input  logic           clk,
    input  logic           rst,
    prbs5_checker_if.slave bus
);
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t      st;
    logic [4:0]  h;
    logic [2:0]  fill;
    logic [4:0]  match_cnt;
    logic [3:0]  err_run;
    logic        locked_r;
    logic        err_pulse_r;
    logic [15:0] err_cnt_r;

    logic exp_bit;
    logic mism;
    logic err_now;

    assign exp_bit = h[4] ^ h[2];
    assign mism    = bus.in_bit != exp_bit;
    assign err_now = bus.in_valid && (st == LOCKED) && mism;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= HUNT;
            h           <= 5'd0;
            fill        <= 3'd0;
            match_cnt   <= 5'd0;
            err_run     <= 4'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= 16'd0;
        end else begin
            err_pulse_r <= err_now;

            // clear wins over the increment but still counts a coincident error
            if (bus.clr_cnt)
                err_cnt_r <= err_now ? 16'd1 : 16'd0;
            else if (err_now && err_cnt_r != 16'hFFFF)
                err_cnt_r <= err_cnt_r + 16'd1;

            if (bus.in_valid) begin
                case (st)
                    HUNT: begin
                        h <= {h[3:0], bus.in_bit};
                        if (fill == 3'd4) begin
                            st        <= VERIFY;
                            fill      <= 3'd0;
                            match_cnt <= 5'd0;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                    VERIFY: begin
                        h <= {h[3:0], bus.in_bit};
                        // an all-zero history predicts zeros forever, so it never counts
                        if (!mism && h != 5'd0) begin
                            if (match_cnt == 5'(LOCK_THRESH - 1)) begin
                                st        <= LOCKED;
                                locked_r  <= 1'b1;
                                match_cnt <= 5'd0;
                                err_run   <= 4'd0;
                            end else begin
                                match_cnt <= match_cnt + 5'd1;
                            end
                        end else begin
                            match_cnt <= 5'd0;
                        end
                    end
                    LOCKED: begin
                        if (mism && err_run == 4'(UNLOCK_THRESH - 1)) begin
                            st       <= HUNT;
                            locked_r <= 1'b0;
                            fill     <= 3'd0;
                            err_run  <= 4'd0;
                        end else begin
                            // flywheel: predict from our own sequence, not the line
                            h       <= {h[3:0], exp_bit};
                            err_run <= mism ? err_run + 4'd1 : 4'd0;
                        end
                    end
                    default: begin
                        st       <= HUNT;
                        locked_r <= 1'b0;
                        fill     <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_cnt_r;
    assign bus.state     = st;
endmodule

// File: doc/prbs5_checker.md
PRBS5_CHECKER -- requirements
Module: prbs5_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 8: consecutive matching bits in VERIFY required to declare lock (range 1..31).
REQ-002 SHALL have parameter UNLOCK_THRESH, default 4: consecutive mismatching bits in LOCKED required to drop lock (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bit is sampled this cycle.
REQ-006 SHALL have port in_bit, input, 1 bit: serial PRBS5 stream, oldest bit first.
REQ-007 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1 bit: checker is in LOCKED.
REQ-009 SHALL have port err_pulse, output, 1 bit: one-cycle flag for a mismatched bit while LOCKED.
REQ-010 SHALL have port err_count, output, 16 bits: saturating count of LOCKED mismatches.
REQ-011 SHALL have port state, output, 2 bits: 00 HUNT, 01 VERIFY, 10 LOCKED.

Function
REQ-012 SHALL check the stream of a 5-bit Fibonacci LFSR that shifts left with feedback d4^d2 and transmits d4 (polynomial x^5+x^3+1, s[n+5] = s[n] ^ s[n+2]).
REQ-013 SHALL keep a 5-bit history h (h[0] newest, h[4] oldest); expected bit = h[4]^h[2].
REQ-014 SHALL update no state (h, counters, FSM, err_count) when in_valid=0, except that err_pulse returns to 0 and clr_cnt still acts.
REQ-015 HUNT: each valid bit shifts into h and increments a fill counter; on the 5th valid bit, go to VERIFY with match counter 0.
REQ-016 VERIFY: each valid bit shifts into h (self-synchronising); a match with h != 0 increments the match counter; a mismatch, or a match with h == 0, clears it.
REQ-017 VERIFY: when the match counter reaches LOCK_THRESH, go to LOCKED; locked=1 from the cycle after that bit.
REQ-018 LOCKED: h SHALL shift in the expected bit, not the received bit (flywheel), so isolated errors do not corrupt prediction.
REQ-019 LOCKED mismatch: err_pulse=1 for exactly the next cycle, err_count increments, and the consecutive-error counter increments; a match clears the consecutive-error counter.
REQ-020 LOCKED: when the consecutive-error counter reaches UNLOCK_THRESH, go to HUNT with fill counter 0, h unchanged, and locked=0 from the next cycle; err_pulse still fires for that bit.
REQ-021 err_count SHALL saturate at 0xFFFF; further errors leave it at 0xFFFF but still pulse err_pulse.
REQ-022 clr_cnt=1 SHALL set err_count to 0; if an error occurs in the same cycle, err_count becomes 1.
REQ-023 All outputs SHALL be registered; latency from sampled bit to err_pulse/locked/err_count is one cycle.
REQ-024 Mismatches outside LOCKED SHALL NOT assert err_pulse or change err_count.

Reset
REQ-025 With rst=0 at a rising edge, next cycle: state=HUNT, h=0, all internal counters 0, locked=0, err_pulse=0, err_count=0.
REQ-026 Reset SHALL override all inputs, including in_valid and clr_cnt, and SHALL abort any state mid-operation.

Verification
REQ-027 Lock: defaults, in_valid=1, stream from a generator seeded 00001 (0000100101 1...) -> state=VERIFY after bit 5, locked=1 the cycle after bit 13, err_count=0.
REQ-028 Single error: once LOCKED, invert one bit -> err_pulse high for one cycle, err_count=1, locked stays 1, following clean bits give no further pulses.
REQ-029 Loss of lock: once LOCKED, invert 4 consecutive bits -> err_count=4, locked=0 and state=HUNT the cycle after the 4th bit; clean stream then relocks after 13 valid bits.
REQ-030 Degenerate and gapped input: all-zero stream for 100 bits -> never leaves VERIFY, locked=0; clean stream with in_valid=0 on alternate cycles -> locks after 13 valid bits.
REQ-031 Counter edges: force 65535 errors then one more -> err_count=0xFFFF; clr_cnt coincident with an error -> err_count=1.
REQ-032 Reset mid-LOCKED: rst=0 for one cycle -> next cycle locked=0, state=00, err_count=0.
